// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake for uart_tx_fifo: the enqueue request and the FIFO status.
// The producer takes the master modport and the transmitter takes the slave modport.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 4
);
  logic [DATA_BITS-1:0] data;
  logic                 data_ready;
  logic                 full;
  logic [FIFO_AW:0]     count;
  logic                 idle;

  modport master (output data, data_ready, input full, count, idle);
  modport slave  (input data, data_ready, output full, count, idle);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with a fixed baud divisor and a
// configurable frame (DATA_BITS payload bits, STOP_BITS stop bits).
// Optional macro UART_TX_PARITY_EN inserts a parity bit after the payload.
// With the macro, PARITY_ODD selects odd parity; without it, PARITY_ODD has no effect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit (low) for CLKS_PER_BIT cycles
// S_DATA   | payload, LSB first, one bit per CLKS_PER_BIT cycles
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | STOP_BITS high bits; on the last cycle, chain to the next queued word
//
// txd and idle are registered from the state held during the previous cycle,
// so the line lags the state machine by one clock.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_fifo_if.slave       bus,
  output logic                txd
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int IW    = $clog2(DATA_BITS);
  localparam logic [TW-1:0]    BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]    DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]    STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] OCC_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW:0]     occ;
  logic [DATA_BITS-1:0] head;
  logic                 bit_end;
  logic                 empty;
  logic                 full_int;
  logic                 push;
  logic                 pop;
  logic                 idle_q;

`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`else
  // Keeps the parity-sense parameter referenced when the parity bit is compiled out.
  logic                 unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  // Full is judged on the pre-edge occupancy, so a write while full is dropped even on a pop edge.
  always_comb begin
    bit_end  = (timer == BIT_LAST);
    empty    = (occ == '0);
    full_int = (occ == OCC_FULL);
    push     = bus.data_ready && !full_int;
    pop      = !empty && ((state == S_IDLE) ||
                          (state == S_STOP && bit_end && idx == STOP_LAST));
    head     = mem[rd_ptr];
  end

  assign bus.full  = full_int;
  assign bus.count = occ;
  assign bus.idle  = idle_q;

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  // FIFO pointers wrap naturally; occupancy carries the extra bit that tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Frame sequencer with registered line and idle outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      timer  <= '0;
      idx    <= '0;
      shreg  <= '0;
      txd    <= 1'b1;
      idle_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      idle_q <= (state == S_IDLE) && empty;
      case (state)
        S_IDLE: begin
          txd   <= 1'b1;
          timer <= '0;
          idx   <= '0;
          if (pop) begin
            shreg <= head;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^head) ^ 1'(PARITY_ODD);
`endif
            state <= S_START;
          end
        end
        S_START: begin
          txd <= 1'b0;
          if (bit_end) begin
            timer <= '0;
            idx   <= '0;
            state <= S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          txd <= shreg[0];
          if (bit_end) begin
            timer <= '0;
            shreg <= shreg >> 1;
            if (idx == DATA_LAST) begin
              idx <= '0;
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          txd <= par_bit;
          if (bit_end) begin
            timer <= '0;
            state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        S_STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            timer <= '0;
            if (idx == STOP_LAST) begin
              idx <= '0;
              // Chaining straight into the next start bit leaves no idle gap between frames.
              if (pop) begin
                shreg <= head;
`ifdef UART_TX_PARITY_EN
                par_bit <= (^head) ^ 1'(PARITY_ODD);
`endif
                state <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, 8N1, 4-deep FIFO.
// With UART_TX_PARITY_EN defined, two extra 7E2/7O2 instances cover the parity bit.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic txd;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_AW(2)) tx_if ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_AW(2), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(tx_if), .txd(txd)
  );

`ifdef UART_TX_PARITY_EN
  logic txd_e, txd_o;
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_AW(4)) pif_e ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_AW(4)) pif_o ();
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_AW(4), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst_n(rst_n), .bus(pif_e), .txd(txd_e)
  );
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_AW(4), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst_n(rst_n), .bus(pif_o), .txd(txd_o)
  );
`endif

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", tx_if.idle); end
    n_checks++; if (tx_if.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", tx_if.full); end
    n_checks++; if (tx_if.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", tx_if.count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL post_reset_txd: got %b want 1", txd); end
  endtask

  task automatic test_single_frame();
    logic [9:0] seq;
    seq = {1'b1, 8'h55, 1'b0};
    tx_if.data = 8'h55;
    tx_if.data_ready = 1'b1;
    tick(1);
    tx_if.data_ready = 1'b0;
    n_checks++; if (tx_if.count !== 3'd1) begin n_fail++; $display("FAIL single_count_k: got %0d want 1", tx_if.count); end
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_k: got %b want 1", tx_if.idle); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_txd_k: got %b want 1", txd); end
    tick(1);
    n_checks++; if (tx_if.idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_k1: got %b want 0", tx_if.idle); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_txd_k1: got %b want 1", txd); end
    n_checks++; if (tx_if.count !== 3'd0) begin n_fail++; $display("FAIL single_count_k1: got %0d want 0", tx_if.count); end
    tick(1);
    for (int t = 0; t < 40; t++) begin
      n_checks++; if (txd !== seq[t/4]) begin n_fail++; $display("FAIL single_line t=%0d: got %b want %b", t, txd, seq[t/4]); end
      n_checks++; if (tx_if.idle !== 1'b0) begin n_fail++; $display("FAIL single_busy t=%0d: got %b want 0", t, tx_if.idle); end
      if (t < 39) tick(1);
    end
    tick(1);
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_end: got %b want 1", tx_if.idle); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_txd_end: got %b want 1", txd); end
  endtask

  task automatic test_back_to_back();
    int exp_cnt [6];
    logic exp_full [6];
    logic [7:0] v;
    logic exp_bit;
    int f, b;
    exp_cnt  = '{1, 1, 2, 3, 4, 4};
    exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tx_if.data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_if.data = 8'hA0 + 8'(i);
      tick(1);
      n_checks++; if (tx_if.count !== 3'(exp_cnt[i])) begin n_fail++; $display("FAIL burst_count e%0d: got %0d want %0d", i, tx_if.count, exp_cnt[i]); end
      n_checks++; if (tx_if.full !== exp_full[i]) begin n_fail++; $display("FAIL burst_full e%0d: got %b want %b", i, tx_if.full, exp_full[i]); end
    end
    tx_if.data_ready = 1'b0;
    // Sample the last cycle of each bit; frames are 40 cycles apart with no gap.
    for (int n = 0; n < 50; n++) begin
      f = n / 10;
      b = n % 10;
      v = 8'hA0 + 8'(f);
      if (b == 0) exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else exp_bit = v[b-1];
      n_checks++; if (txd !== exp_bit) begin n_fail++; $display("FAIL burst_line frame=%0d bit=%0d: got %b want %b", f, b, txd, exp_bit); end
      if (b == 0) begin
        n_checks++; if (tx_if.count !== 3'(4 - f)) begin n_fail++; $display("FAIL burst_drain frame=%0d: got %0d want %0d", f, tx_if.count, 4 - f); end
      end
      if (n < 49) tick(4);
    end
    tick(1);
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL burst_idle_end: got %b want 1", tx_if.idle); end
    n_checks++; if (tx_if.count !== 3'd0) begin n_fail++; $display("FAIL burst_count_end: got %0d want 0", tx_if.count); end
  endtask

  task automatic test_simul_push_pop();
    tx_if.data_ready = 1'b1;
    tx_if.data = 8'hB0; tick(1);
    tx_if.data = 8'hB1; tick(1);
    tx_if.data = 8'hB2; tick(1);
    tx_if.data_ready = 1'b0;
    n_checks++; if (tx_if.count !== 3'd2) begin n_fail++; $display("FAIL simul_pre: got %0d want 2", tx_if.count); end
    tick(38);
    tx_if.data_ready = 1'b1;
    tx_if.data = 8'hB3; tick(1);
    n_checks++; if (tx_if.count !== 3'd2) begin n_fail++; $display("FAIL simul_push_pop: got %0d want 2", tx_if.count); end
    tx_if.data = 8'hB4; tick(1);
    n_checks++; if (tx_if.count !== 3'd3) begin n_fail++; $display("FAIL simul_fill3: got %0d want 3", tx_if.count); end
    tx_if.data = 8'hB5; tick(1);
    n_checks++; if (tx_if.count !== 3'd4) begin n_fail++; $display("FAIL simul_fill4: got %0d want 4", tx_if.count); end
    n_checks++; if (tx_if.full !== 1'b1) begin n_fail++; $display("FAIL simul_full: got %b want 1", tx_if.full); end
    tx_if.data_ready = 1'b0;
    tick(37);
    tx_if.data_ready = 1'b1;
    tx_if.data = 8'hB6; tick(1);
    tx_if.data_ready = 1'b0;
    n_checks++; if (tx_if.count !== 3'd3) begin n_fail++; $display("FAIL simul_full_drop: got %0d want 3", tx_if.count); end
    n_checks++; if (tx_if.full !== 1'b0) begin n_fail++; $display("FAIL simul_full_clear: got %b want 0", tx_if.full); end
    tick(160);
    n_checks++; if (tx_if.idle !== 1'b0) begin n_fail++; $display("FAIL simul_busy_last: got %b want 0", tx_if.idle); end
    tick(1);
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL simul_idle_end: got %b want 1", tx_if.idle); end
    n_checks++; if (tx_if.count !== 3'd0) begin n_fail++; $display("FAIL simul_count_end: got %0d want 0", tx_if.count); end
  endtask

  task automatic test_reset_mid_frame();
    logic saw_low;
    tx_if.data_ready = 1'b1;
    tx_if.data = 8'h00; tick(1);
    tx_if.data = 8'hC1; tick(1);
    tx_if.data = 8'hC2; tick(1);
    tx_if.data = 8'hC3; tick(1);
    tx_if.data_ready = 1'b0;
    tick(11);
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit2: got %b want 0", txd); end
    n_checks++; if (tx_if.count !== 3'd3) begin n_fail++; $display("FAIL rstmid_queued: got %0d want 3", tx_if.count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    n_checks++; if (tx_if.count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", tx_if.count); end
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got %b want 1", tx_if.idle); end
    tick(2);
    rst_n = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    n_checks++; if (saw_low !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_frame: got %b want 0", saw_low); end
    n_checks++; if (tx_if.idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_after: got %b want 1", tx_if.idle); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [6:0] v;
    logic exp_e, exp_o;
    v = 7'h07;
    pif_e.data = v; pif_o.data = v;
    pif_e.data_ready = 1'b1; pif_o.data_ready = 1'b1;
    tick(1);
    pif_e.data_ready = 1'b0; pif_o.data_ready = 1'b0;
    tick(2);
    n_checks++; if (txd_e !== 1'b0) begin n_fail++; $display("FAIL par_even_start: got %b want 0", txd_e); end
    n_checks++; if (txd_o !== 1'b0) begin n_fail++; $display("FAIL par_odd_start: got %b want 0", txd_o); end
    tick(3);
    for (int b = 0; b < 11; b++) begin
      if (b == 0) begin exp_e = 1'b0; exp_o = 1'b0; end
      else if (b <= 7) begin exp_e = v[b-1]; exp_o = v[b-1]; end
      else if (b == 8) begin exp_e = 1'b1; exp_o = 1'b0; end
      else begin exp_e = 1'b1; exp_o = 1'b1; end
      n_checks++; if (txd_e !== exp_e) begin n_fail++; $display("FAIL par_even bit=%0d: got %b want %b", b, txd_e, exp_e); end
      n_checks++; if (txd_o !== exp_o) begin n_fail++; $display("FAIL par_odd bit=%0d: got %b want %b", b, txd_o, exp_o); end
      if (b < 10) tick(4);
    end
    n_checks++; if (pif_e.idle !== 1'b0) begin n_fail++; $display("FAIL par_busy_last: got %b want 0", pif_e.idle); end
    tick(1);
    n_checks++; if (pif_e.idle !== 1'b1) begin n_fail++; $display("FAIL par_even_idle: got %b want 1", pif_e.idle); end
    n_checks++; if (pif_o.idle !== 1'b1) begin n_fail++; $display("FAIL par_odd_idle: got %b want 1", pif_o.idle); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    tx_if.data = '0;
    tx_if.data_ready = 1'b0;
`ifdef UART_TX_PARITY_EN
    pif_e.data = '0; pif_e.data_ready = 1'b0;
    pif_o.data = '0; pif_o.data_ready = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the single-byte UART transmitter.
- Adds a configurable frame format (data bits, stop bits, optional parity) and a runtime-free fixed baud divisor.
- Adds an input FIFO so producers (camera/debug logic) can queue bursts without polling IDLE per byte.
- Drives the board TXD pin directly from a registered output.

Parameters:
CLKS_PER_BIT, 234, clock cycles per serial bit (27 MHz / 115200 baud); legal range >= 2
DATA_BITS, 8, payload bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words (default 16)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored unless UART_TX_PARITY_EN is defined

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST_N  input  1  asynchronous, active-low reset
DATA  input  DATA_BITS  word to enqueue
DATA_READY  input  1  enqueue request, sampled each rising edge
FULL  output  1  FIFO holds 2**FIFO_AW words; writes are ignored
COUNT  output  FIFO_AW+1  words currently queued, excluding the word being shifted
TXD  output  1  serial line; idles high
IDLE  output  1  FIFO empty AND shifter in S_IDLE

Behaviour:
- Reset (RST_N low, asynchronous):
  - TXD=1, IDLE=1, FULL=0, COUNT=0.
  - FIFO pointers cleared; state S_IDLE; bit timer and bit index cleared.
  - A reset asserted mid-frame truncates the frame and raises TXD immediately; queued words are discarded.
- Write rule:
  - One word is enqueued on every rising edge where DATA_READY=1 and FULL=0.
  - A level-held DATA_READY enqueues one copy per cycle until FULL.
  - A write while FULL=1 is dropped silently, even if a pop occurs on the same edge.
- Pop rule:
  - A word is popped on the edge the FSM loads the shift register.
  - Simultaneous write and pop (not full) leaves COUNT unchanged.
  - Pointers wrap modulo 2**FIFO_AW; FULL/empty are derived from a FIFO_AW+1-bit occupancy count.
- FSM states:
  - S_IDLE: TXD=1. If FIFO is non-empty: pop, load shifter, go to S_START.
  - S_START: TXD=0 for CLKS_PER_BIT cycles.
  - S_DATA: TXD = shifter LSB. Shift right every CLKS_PER_BIT cycles. Leave after DATA_BITS bits (LSB first).
  - S_PARITY: present only with the macro. TXD = parity bit for CLKS_PER_BIT cycles.
  - S_STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles. In the final cycle, if FIFO is non-empty: pop, load, go directly to S_START (zero idle gap between frames); else go to S_IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT). Reloads to 0 on every bit boundary.
- Latency: with IDLE=1, a write accepted at edge k produces TXD falling at edge k+2. IDLE drops at edge k+1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with the macro and 0 without.
- IDLE returns to 1 on the edge S_STOP ends with the FIFO empty.
- TXD is a flop output; no combinational path from any input.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - S_PARITY is inserted after the data bits.
  - Parity bit = XOR of the DATA_BITS payload bits; inverted when PARITY_ODD=1.
  - Parity is computed at load time and stored in a 1-bit register.
- Undefined:
  - No S_PARITY state, no parity register.
  - PARITY_ODD is unused; frames contain no parity bit.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no macro. One-cycle write of 0x55.
  - TXD falls 2 cycles later.
  - Line sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - IDLE=1 exactly 40 cycles after TXD fell.
- FIFO_AW=2. DATA_READY held high with DATA=0xA0..0xA5 over 6 cycles.
  - COUNT reaches 4 with FULL=1 (the first word popped into the shifter).
  - 0xA5 is dropped.
  - Frames 0xA0..0xA4 go out back-to-back with no gap between stop and start bits.
- Write and pop on the same edge with COUNT=2 -> COUNT stays 2. Write with FULL=1 on a pop edge -> write ignored and COUNT decrements.
- RST_N pulsed low at the 3rd data bit of 0x00 with 3 words queued.
  - TXD=1 asynchronously, COUNT=0, IDLE=1.
  - After release, no frame is emitted.
- UART_TX_PARITY_EN, PARITY_ODD=0, DATA_BITS=7, STOP_BITS=2. Send 0x07.
  - Parity bit = 1, then 2 stop bits.
  - Frame = 11*CLKS_PER_BIT cycles.
  - Repeat with PARITY_ODD=1 -> parity bit = 0.
- Loopback against uart_receive at 27 MHz, CLKS_PER_BIT=234. Send bytes 0..255 via the FIFO.
  - Receiver reports every value in order with no RXD_READY gaps or errors.
